// File: rtl/dmem_store_ctrl.sv
// Store-side data-memory controller: captures a store, checks alignment,
// lane-aligns data and drives memory with byte enables for a fixed wait period.
module dmem_store_ctrl #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int WAIT_STATES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  MemWrite,
   input  logic [1:0]            StoreSize,
   input  logic [ADDR_WIDTH-1:0] Addr,
   input  logic [DATA_WIDTH-1:0] DataRegB,
   output logic                  busy,
   output logic                  done,
   output logic                  misaligned,
   output logic                  DMemWE,
   output logic [ADDR_WIDTH-1:0] DMemAddr,
   output logic [DATA_WIDTH-1:0] DMemWData,
   output logic [3:0]            DMemByteEn
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2,
      FAULT = 2'd3
   } state_t;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

   state_t                state, state_nx;
   logic [3:0]            cnt, cnt_nx;
   logic                  fault;
   logic                  accept;
   logic [DATA_WIDTH-1:0] lane_data;
   logic [3:0]            lane_ben;

   // Size/alignment fault, evaluated on the live request inputs at capture.
   always_comb begin
      fault = 1'b0;
      case (StoreSize)
         SIZE_BYTE: fault = 1'b0;
         SIZE_HALF: fault = Addr[0];
         SIZE_WORD: fault = |Addr[1:0];
         default:   fault = 1'b1;
      endcase
   end

   // Little-endian lane placement; the illegal size is never written.
   always_comb begin
      lane_data = DataRegB;
      lane_ben  = 4'b1111;
      case (StoreSize)
         SIZE_BYTE: begin
            lane_data = {4{DataRegB[7:0]}};
            lane_ben  = 4'b0001 << Addr[1:0];
         end
         SIZE_HALF: begin
            lane_data = {2{DataRegB[15:0]}};
            lane_ben  = Addr[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            lane_data = DataRegB;
            lane_ben  = 4'b1111;
         end
      endcase
   end

   assign accept = (state == IDLE) && MemWrite;

   // NOTE: every signal written here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         IDLE: begin
            if (MemWrite) begin
               if (fault) begin
                  state_nx = FAULT;
               end else begin
                  state_nx = WRITE;
                  cnt_nx   = WAIT_LOAD;
               end
            end
         end
         WRITE: begin
            if (cnt == 4'd0) state_nx = DONE;
            else             cnt_nx   = cnt - 4'd1;
         end
         DONE:    state_nx = IDLE;
         FAULT:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // Outputs are flops loaded from the next state, so they align with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy       <= 1'b0;
         done       <= 1'b0;
         misaligned <= 1'b0;
         DMemWE     <= 1'b0;
      end else begin
         busy       <= (state_nx != IDLE);
         done       <= (state_nx == DONE);
         misaligned <= (state_nx == FAULT);
         DMemWE     <= (state_nx == WRITE);
      end
   end

   // Captured copies; they hold while idle so inputs may change after capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         DMemAddr   <= '0;
         DMemWData  <= '0;
         DMemByteEn <= 4'b0000;
      end else if (accept) begin
         if (fault) begin
            DMemByteEn <= 4'b0000;
         end else begin
            DMemAddr   <= {Addr[ADDR_WIDTH-1:2], 2'b00};
            DMemWData  <= lane_data;
            DMemByteEn <= lane_ben;
         end
      end
   end

endmodule
